div_share_arbiter: RTL and testbench

- Shares one `divisor_restoring_7bits` instance among N_REQ requesters.
- Arbitrates requests round-robin and issues one division at a time. The divider gets a one-cycle `start` pulse.
- Waits for the divider's `done`, then routes Q/R back to the granted requester with a one-cycle valid pulse.
- Sits between client logic and the divider. The divider's ports connect directly to the `div_*` ports.

---
 rtl/div_arb_pkg.sv | 15 +
 rtl/div_share_arbiter_rr_picker.sv | 29 ++
 rtl/div_share_arbiter.sv | 151 +++++++++++++++
 tb/tb_div_share_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
package div_arb_pkg;

    localparam int DIV_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        ARM,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/div_share_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             found,
    output logic [IDW-1:0]   idx
);

    localparam int unsigned NU = N_REQ;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        int unsigned j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned k = 0; k < NU; k++) begin
            j = (ptr + k) % NU;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one 7-bit restoring divider among N_REQ requesters, round-robin,
// one operation at a time.
// Optional macro DIV_ARB_ZERO_BYPASS_EN: a zero divisor skips the divider and
// answers Q=all ones, R=dividend, flagged on rsp_dz.
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = DIV_W,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DIV_ARB_ZERO_BYPASS_EN
    output logic               rsp_dz,
`endif
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_q,
    output logic [W-1:0]       rsp_r,
    output logic [IDW-1:0]     rsp_id,
    output logic               busy,
    output logic               div_start,
    output logic [W-1:0]       div_a,
    output logic [W-1:0]       div_b,
    input  logic [W-1:0]       div_q,
    input  logic [W-1:0]       div_r,
    input  logic               div_done
);

    localparam int unsigned NU = N_REQ;

    arb_state_t     state, nxt;
    logic [IDW-1:0] ptr, cur_id, pick_idx;
    logic           pick_found;
    logic [W-1:0]   a_sel, b_sel;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    logic           dz_q;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Operand slices of the currently granted requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (cur_id == IDW'(i)) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Datapath: grant index, divider operands, held response, RR pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= '0;
            cur_id <= '0;
            div_a  <= '0;
            div_b  <= '0;
            rsp_q  <= '0;
            rsp_r  <= '0;
            rsp_id <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            dz_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (pick_found) cur_id <= pick_idx;
                GRANT: begin
                    div_a <= a_sel;
                    div_b <= b_sel;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    if (b_sel == '0) begin
                        rsp_q  <= '1;
                        rsp_r  <= a_sel;
                        rsp_id <= cur_id;
                        dz_q   <= 1'b1;
                    end
`endif
                end
                WAIT: if (div_done) begin
                    rsp_q  <= div_q;
                    rsp_r  <= div_r;
                    rsp_id <= cur_id;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    dz_q   <= 1'b0;
`endif
                end
                RESP: ptr <= (cur_id == IDW'(NU - 1)) ? '0 : cur_id + IDW'(1);
                default: ;
            endcase
        end
    end

    // Next state and pulse outputs decoded from the registered state.
    always_comb begin
        nxt       = state;
        gnt       = '0;
        rsp_valid = '0;
        div_start = 1'b0;
        busy      = (state != IDLE);
`ifdef DIV_ARB_ZERO_BYPASS_EN
        rsp_dz    = 1'b0;
`endif
        case (state)
            IDLE:  if (pick_found) nxt = GRANT;
            GRANT: begin
                gnt[cur_id] = 1'b1;
                nxt         = ISSUE;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                if (b_sel == '0) nxt = RESP;
`endif
            end
            ISSUE: begin
                div_start = 1'b1;
                nxt       = ARM;
            end
            // done may still be high from the previous operation
            ARM:   if (!div_done) nxt = WAIT;
            WAIT:  if (div_done) nxt = RESP;
            RESP: begin
                rsp_valid[cur_id] = 1'b1;
                nxt               = IDLE;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                rsp_dz            = dz_q;
`endif
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter with a behavioural divider model.
module tb_div_share_arbiter;
    import div_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 7;
    localparam int IDW = 2;
    localparam int unsigned LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   gnt, rsp_valid;
    logic [W-1:0]   rsp_q, rsp_r, div_a, div_b, div_q, div_r;
    logic [IDW-1:0] rsp_id;
    logic           busy, div_start, div_done;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    logic           rsp_dz;
`endif

    div_share_arbiter #(
        .N_REQ (N),
        .W     (W),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DIV_ARB_ZERO_BYPASS_EN
        .rsp_dz    (rsp_dz),
`endif
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .div_r     (div_r),
        .div_done  (div_done)
    );

    // Divider model: done is a level that stays high until the next start
    // (and for stale_hold extra cycles after it); results appear with done.
    logic [W-1:0] m_a, m_b;
    int unsigned  m_cnt, m_hold;
    int unsigned  stale_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_done <= 1'b0;
            div_q    <= '0;
            div_r    <= '0;
            m_a      <= '0;
            m_b      <= '0;
            m_cnt    <= 0;
            m_hold   <= 0;
        end else if (div_start) begin
            m_a <= div_a;
            m_b <= div_b;
            if (stale_hold != 0) m_hold <= stale_hold;
            else begin
                div_done <= 1'b0;
                m_cnt    <= LAT;
            end
        end else if (m_hold != 0) begin
            m_hold <= m_hold - 1;
            if (m_hold == 1) begin
                div_done <= 1'b0;
                m_cnt    <= LAT;
            end
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                div_done <= 1'b1;
                if (m_b == '0) begin
                    div_q <= '1;
                    div_r <= m_a;
                end else begin
                    div_q <= m_a / m_b;
                    div_r <= m_a % m_b;
                end
            end
        end
    end

    typedef struct {
        int           id;
        logic [W-1:0] a, b, q, r;
    } vec_t;

    typedef struct {
        int           id;
        logic [W-1:0] q, r;
        bit           dz;
    } exp_t;

    vec_t         vt[10];
    exp_t         sbq[$];
    int           gnt_log[$];
    logic [W-1:0] eq[N], er[N];
    bit           edz[N];
    logic [N-1:0] hold;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, g_cyc = 0, lat_last = 0;
    int n_gnt = 0, n_rsp = 0, starts = 0;
    bit busy_track = 0;
    int busy_low = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic set_op(input int k);
        int id;
        id = vt[k].id;
        req_a[id*W +: W] = vt[k].a;
        req_b[id*W +: W] = vt[k].b;
        eq[id] = vt[k].q;
        er[id] = vt[k].r;
`ifdef DIV_ARB_ZERO_BYPASS_EN
        edz[id] = (vt[k].b == '0);
`else
        edz[id] = 1'b0;
`endif
    endtask

    // One clock; sample #1 after the edge; scoreboard push on gnt, pop on rsp.
    task automatic tick();
        int   gid;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            if (busy_track && !busy) busy_low++;
            if (div_start) starts++;
            if (gnt != '0) begin
                gid = 0;
                for (int i = N - 1; i >= 0; i--) if (gnt[i]) gid = i;
                check("gnt_onehot", 32'($countones(gnt)), 32'd1);
                n_gnt++;
                gnt_log.push_back(gid);
                sbq.push_back('{gid, eq[gid], er[gid], edz[gid]});
                if (!hold[gid]) req[gid] = 1'b0;
                g_cyc = cyc;
            end
            if (rsp_valid != '0) begin
                n_rsp++;
                if (sbq.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                else begin
                    e = sbq.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_q", 32'(rsp_q), 32'(e.q));
                    check("rsp_r", 32'(rsp_r), 32'(e.r));
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
`endif
                    lat_last = cyc - g_cyc;
                end
            end
        end
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while ((sbq.size() != 0 || req != '0 || busy) && c < maxc) begin
            tick();
            c++;
        end
        check("drain_timeout", 32'(c < maxc), 32'd1);
    endtask

    task automatic wait_gnts(input int target, input int maxc);
        int c = 0;
        while (n_gnt < target && c < maxc) begin
            tick();
            c++;
        end
        check("gnt_timeout", 32'(n_gnt >= target), 32'd1);
    endtask

    task automatic wait_rsps(input int target, input int maxc);
        int c = 0;
        while (n_rsp < target && c < maxc) begin
            tick();
            c++;
        end
        check("rsp_timeout", 32'(n_rsp >= target), 32'd1);
    endtask

    task automatic wait_starts(input int target, input int maxc);
        int c = 0;
        while (starts < target && c < maxc) begin
            tick();
            c++;
        end
        check("start_timeout", 32'(starts >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_div_start"}, 32'(div_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rsp_q"}, 32'(rsp_q), 32'd0);
        check({tag, "_rsp_r"}, 32'(rsp_r), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_div_a"}, 32'(div_a), 32'd0);
        check({tag, "_div_b"}, 32'(div_b), 32'd0);
`ifdef DIV_ARB_ZERO_BYPASS_EN
        check({tag, "_rsp_dz"}, 32'(rsp_dz), 32'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, r0, s0, lat_norm;

        vt[0] = '{0, 7'd7,   7'd2,  7'd3,   7'd1};
        vt[1] = '{0, 7'd50,  7'd7,  7'd7,   7'd1};
        vt[2] = '{1, 7'd127, 7'd13, 7'd9,   7'd10};
        vt[3] = '{2, 7'd99,  7'd5,  7'd19,  7'd4};
        vt[4] = '{3, 7'd7,   7'd2,  7'd3,   7'd1};
        vt[5] = '{0, 7'd20,  7'd3,  7'd6,   7'd2};
        vt[6] = '{2, 7'd9,   7'd4,  7'd2,   7'd1};
        vt[7] = '{1, 7'd50,  7'd0,  7'd127, 7'd50};
        vt[8] = '{1, 7'd100, 7'd9,  7'd11,  7'd1};
        vt[9] = '{1, 7'd45,  7'd6,  7'd7,   7'd3};

        req        = '0;
        req_a      = '0;
        req_b      = '0;
        hold       = '0;
        stale_hold = 0;
        for (int i = 0; i < N; i++) begin
            eq[i]  = '0;
            er[i]  = '0;
            edz[i] = 1'b0;
        end

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // All four requesters at once: grant order 0..3 from pointer 0
        for (int k = 1; k <= 4; k++) set_op(k);
        g0 = gnt_log.size();
        r0 = n_rsp;
        s0 = starts;
        req = '1;
        wait_gnts(n_gnt + 1, 50);
        busy_track = 1;
        busy_low   = 0;
        wait_rsps(r0 + 4, 200);
        busy_track = 0;
        wait_idle(50);
        for (int k = 0; k < 4; k++) check("order4", 32'(gnt_log[g0 + k]), 32'(k));
        check("starts4", 32'(starts - s0), 32'd4);
        check("busy_low_gaps", 32'(busy_low), 32'd3);

        // Single request: requester 0, 7/2
        set_op(0);
        g0 = n_gnt;
        s0 = starts;
        req[0] = 1'b1;
        wait_idle(100);
        check("single_gnts", 32'(n_gnt - g0), 32'd1);
        check("single_starts", 32'(starts - s0), 32'd1);
        check("single_id", 32'(gnt_log[gnt_log.size() - 1]), 32'd0);

        // Fairness: req[0] held, req[2] raised once
        set_op(5);
        hold[0] = 1'b1;
        req[0]  = 1'b1;
        g0 = n_gnt;
        wait_gnts(g0 + 1, 50);
        set_op(6);
        req[2] = 1'b1;
        wait_gnts(g0 + 2, 100);
        check("fair_second", 32'(gnt_log[gnt_log.size() - 1]), 32'd2);
        wait_gnts(g0 + 3, 100);
        check("fair_third", 32'(gnt_log[gnt_log.size() - 1]), 32'd0);
        hold[0] = 1'b0;
        wait_idle(100);

        // Stale done: reference latency, then done held high after start
        set_op(8);
        req[1] = 1'b1;
        wait_idle(100);
        lat_norm   = lat_last;
        stale_hold = 4;
        set_op(9);
        req[1] = 1'b1;
        wait_idle(100);
        check("stale_extra_lat", 32'(lat_last), 32'(lat_norm + 4));
        stale_hold = 0;

        // Zero divisor
        set_op(7);
        s0 = starts;
        req[1] = 1'b1;
        wait_idle(100);
`ifdef DIV_ARB_ZERO_BYPASS_EN
        check("zero_starts", 32'(starts - s0), 32'd0);
`else
        check("zero_starts", 32'(starts - s0), 32'd1);
`endif

        // Reset while waiting on the divider
        set_op(6);
        s0 = starts;
        req[2] = 1'b1;
        wait_starts(s0 + 1, 50);
        tick();
        tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sbq.delete();
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        r0 = n_rsp;
        repeat (20) tick();
        check("no_rsp_after_rst", 32'(n_rsp - r0), 32'd0);
        set_op(5);
        set_op(4);
        g0 = gnt_log.size();
        req[0] = 1'b1;
        req[3] = 1'b1;
        wait_idle(200);
        check("post_rst_first", 32'(gnt_log[g0]), 32'd0);
        check("post_rst_second", 32'(gnt_log[g0 + 1]), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
